// File: rtl/alarm_zone_ctrl.sv
// Alarm zone controller: arms/disarms on a user code, runs an entry delay
// for ordinary zones, goes straight to alarm for instant zones or repeated
// bad codes, and holds the alarm for a minimum time before re-arming.
module alarm_zone_ctrl #(
    parameter int                NUM_ZONES   = 4,
    parameter int                ENTRY_DELAY = 16,
    parameter int                ALARM_HOLD  = 64,
    parameter int                CODE_W      = 4,
    parameter logic [CODE_W-1:0] ARM_CODE    = 4'hA,
    parameter int                MAX_BAD     = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               ena,
    input  logic                               arm_req,
    input  logic                               disarm_req,
    input  logic [CODE_W-1:0]                  code_in,
    input  logic [NUM_ZONES-1:0]               zone_in,
    input  logic [NUM_ZONES-1:0]               zone_bypass,
    input  logic [NUM_ZONES-1:0]               zone_instant,
    output logic                               alarm,
    output logic [1:0]                         state,
    output logic [1:0]                         next_state,
    output logic [NUM_ZONES-1:0]               zone_latched,
    output logic [$clog2(ENTRY_DELAY+1)-1:0]   delay_left,
    output logic                               arm_fail,
    output logic                               code_err
);

    localparam int DW = $clog2(ENTRY_DELAY + 1);
    localparam int HW = $clog2(ALARM_HOLD + 1);
    localparam int BW = $clog2(MAX_BAD + 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_ARMED = 2'b01,
        ST_TRIG  = 2'b10,
        ST_ALARM = 2'b11
    } state_t;

    state_t               state_r;
    state_t               nxt_s;
    logic                 alarm_r;
    logic [DW-1:0]        dly_r;
    logic [HW-1:0]        hold_r;
    logic [BW-1:0]        bad_cnt_r;
    logic [NUM_ZONES-1:0] lat_r;
    logic                 arm_fail_r;
    logic                 code_err_r;

    logic [NUM_ZONES-1:0] active_s;
    logic                 any_active_s;
    logic                 instant_hit_s;
    logic                 code_ok_s;
    logic                 good_req_s;
    logic                 good_arm_s;
    logic                 good_disarm_s;
    logic                 bad_req_s;
    logic                 tamper_s;
    logic                 arm_fail_s;

    // Request qualification and zone summaries; a disarm always shadows a simultaneous arm.
    always_comb begin
        active_s      = zone_in & ~zone_bypass;
        any_active_s  = |active_s;
        instant_hit_s = |(active_s & zone_instant);
        code_ok_s     = (code_in == ARM_CODE);
        good_req_s    = (arm_req | disarm_req) & code_ok_s;
        good_disarm_s = disarm_req & code_ok_s;
        good_arm_s    = arm_req & ~disarm_req & code_ok_s;
        bad_req_s     = (arm_req | disarm_req) & ~code_ok_s;
        tamper_s      = bad_req_s && (bad_cnt_r >= BW'(MAX_BAD - 1));
        arm_fail_s    = (state_r == ST_OFF) && good_arm_s && any_active_s;
    end

    // Next-state decision; a valid disarm outranks every zone, tamper or timer event.
    always_comb begin
        nxt_s = state_r;
        case (state_r)
            ST_OFF: begin
                if (good_arm_s && !any_active_s) nxt_s = ST_ARMED;
                else                             nxt_s = ST_OFF;
            end
            ST_ARMED: begin
                if (good_disarm_s)                  nxt_s = ST_OFF;
                else if (tamper_s || instant_hit_s) nxt_s = ST_ALARM;
                else if (any_active_s)              nxt_s = ST_TRIG;
                else                                nxt_s = ST_ARMED;
            end
            ST_TRIG: begin
                if (good_disarm_s)                                        nxt_s = ST_OFF;
                else if (tamper_s || instant_hit_s || dly_r == DW'(1))    nxt_s = ST_ALARM;
                else                                                      nxt_s = ST_TRIG;
            end
            ST_ALARM: begin
                if (good_disarm_s)                          nxt_s = ST_OFF;
                else if (hold_r == HW'(1) && !any_active_s) nxt_s = ST_ARMED;
                else                                        nxt_s = ST_ALARM;
            end
            default: nxt_s = ST_OFF;
        endcase
    end

    // Combinational next-state view; frozen to the current state while disabled.
    always_comb begin
        if (ena) next_state = nxt_s;
        else     next_state = state_r;
    end

    // State, alarm flag and the entry-delay / alarm-hold down-counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_OFF;
            alarm_r <= 1'b0;
            dly_r   <= {DW{1'b0}};
            hold_r  <= {HW{1'b0}};
        end else if (ena) begin
            state_r <= nxt_s;
            alarm_r <= (nxt_s == ST_ALARM);
            if (nxt_s == ST_TRIG) begin
                if (state_r == ST_TRIG) dly_r <= dly_r - DW'(1);
                else                    dly_r <= DW'(ENTRY_DELAY);
            end else begin
                dly_r <= {DW{1'b0}};
            end
            if (nxt_s == ST_ALARM) begin
                if (state_r == ST_ALARM && hold_r != HW'(1)) hold_r <= hold_r - HW'(1);
                else                                         hold_r <= HW'(ALARM_HOLD);
            end else begin
                hold_r <= {HW{1'b0}};
            end
        end else begin
            state_r <= state_r;
            alarm_r <= alarm_r;
            dly_r   <= dly_r;
            hold_r  <= hold_r;
        end
    end

    // Sticky record of offending zones; only a successful arm wipes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_r <= {NUM_ZONES{1'b0}};
        end else if (ena) begin
            if (state_r == ST_OFF && nxt_s == ST_ARMED) begin
                lat_r <= {NUM_ZONES{1'b0}};
            end else if (state_r == ST_TRIG || state_r == ST_ALARM ||
                         (state_r == ST_ARMED && nxt_s != ST_ARMED)) begin
                lat_r <= lat_r | active_s;
            end else begin
                lat_r <= lat_r;
            end
        end else begin
            lat_r <= lat_r;
        end
    end

    // Saturating bad-code counter and the one-cycle refusal / bad-code pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bad_cnt_r  <= {BW{1'b0}};
            arm_fail_r <= 1'b0;
            code_err_r <= 1'b0;
        end else if (ena) begin
            if (bad_req_s) begin
                if (bad_cnt_r != BW'(MAX_BAD)) bad_cnt_r <= bad_cnt_r + BW'(1);
                else                           bad_cnt_r <= bad_cnt_r;
            end else if (good_req_s) begin
                bad_cnt_r <= {BW{1'b0}};
            end else begin
                bad_cnt_r <= bad_cnt_r;
            end
            arm_fail_r <= arm_fail_s;
            code_err_r <= bad_req_s;
        end else begin
            bad_cnt_r  <= bad_cnt_r;
            arm_fail_r <= 1'b0;
            code_err_r <= 1'b0;
        end
    end

    assign state        = state_r;
    assign alarm        = alarm_r;
    assign delay_left   = dly_r;
    assign zone_latched = lat_r;
    // Pulses must read low in any cycle the block is disabled.
    assign arm_fail     = arm_fail_r & ena;
    assign code_err     = code_err_r & ena;

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Bench for alarm_zone_ctrl: directed scenarios followed by randomized
// traffic, all checked against a timestamp-based reference model.
module tb_alarm_zone_ctrl;

    localparam int         NZ   = 4;
    localparam int         ED   = 16;
    localparam int         AH   = 64;
    localparam int         MB   = 3;
    localparam logic [3:0] CODE = 4'hA;

    logic          clk = 1'b0;
    logic          rst_n, ena, arm_req, disarm_req;
    logic [3:0]    code_in, zone_in, zone_bypass, zone_instant;
    logic          alarm, arm_fail, code_err;
    logic [1:0]    state, next_state;
    logic [NZ-1:0] zone_latched;
    logic [4:0]    delay_left;

    int checks = 0;
    int errors = 0;

    // Reference model: mode plus the enabled-cycle timestamp of the last entry
    // into the delay and alarm phases; counters are derived from elapsed time.
    int         m_state = 0;
    int         m_bad   = 0;
    int         en_t    = 0;
    int         t_trig  = 0;
    int         t_alarm = 0;
    logic [3:0] m_lat   = 4'b0000;
    bit         m_af    = 1'b0;
    bit         m_ce    = 1'b0;

    always #5 clk = ~clk;

    alarm_zone_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .arm_req      (arm_req),
        .disarm_req   (disarm_req),
        .code_in      (code_in),
        .zone_in      (zone_in),
        .zone_bypass  (zone_bypass),
        .zone_instant (zone_instant),
        .alarm        (alarm),
        .state        (state),
        .next_state   (next_state),
        .zone_latched (zone_latched),
        .delay_left   (delay_left),
        .arm_fail     (arm_fail),
        .code_err     (code_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_next();
        logic [3:0] act;
        bit any_act, inst, ok, dis_ok, arm_ok, bad, tamper;
        act     = zone_in & ~zone_bypass;
        any_act = (act != 4'b0000);
        inst    = ((act & zone_instant) != 4'b0000);
        ok      = (code_in == CODE);
        dis_ok  = disarm_req && ok;
        arm_ok  = arm_req && !disarm_req && ok;
        bad     = (arm_req || disarm_req) && !ok;
        tamper  = bad && (m_bad + 1 >= MB);
        case (m_state)
            0: return (arm_ok && !any_act) ? 1 : 0;
            1: return dis_ok ? 0 : (tamper || inst) ? 3 : any_act ? 2 : 1;
            2: return dis_ok ? 0 : (tamper || inst || (en_t - t_trig) == ED - 1) ? 3 : 2;
            3: return dis_ok ? 0 : (((en_t - t_alarm) % AH) == AH - 1 && !any_act) ? 1 : 3;
            default: return 0;
        endcase
    endfunction

    task automatic model_update(input int nx);
        logic [3:0] act;
        bit ok, bad;
        act = zone_in & ~zone_bypass;
        ok  = (code_in == CODE);
        bad = (arm_req || disarm_req) && !ok;
        if (!rst_n) begin
            m_state = 0; m_lat = 4'b0000; m_bad = 0; m_af = 1'b0; m_ce = 1'b0;
        end else if (!ena) begin
            m_af = 1'b0; m_ce = 1'b0;
        end else begin
            if (m_state == 0 && nx == 1)                          m_lat = 4'b0000;
            else if (m_state >= 2 || (m_state == 1 && nx != 1))   m_lat = m_lat | act;
            if (nx == 2 && m_state != 2) t_trig  = en_t + 1;
            if (nx == 3 && m_state != 3) t_alarm = en_t + 1;
            en_t++;
            if (bad)                                 m_bad = (m_bad + 1 > MB) ? MB : m_bad + 1;
            else if ((arm_req || disarm_req) && ok)  m_bad = 0;
            m_af    = (m_state == 0) && arm_req && !disarm_req && ok && (act != 4'b0000);
            m_ce    = bad;
            m_state = nx;
        end
    endtask

    // One clock: drive on the falling edge, compare every output, then advance the model.
    task automatic cyc(input bit r, input bit e, input bit ar, input bit dr,
                       input logic [3:0] code, input logic [3:0] zi,
                       input logic [3:0] zb, input logic [3:0] zs);
        int nx;
        @(negedge clk);
        rst_n = r; ena = e; arm_req = ar; disarm_req = dr;
        code_in = code; zone_in = zi; zone_bypass = zb; zone_instant = zs;
        #1;
        nx = model_next();
        check_eq("state", state, m_state);
        check_eq("alarm", alarm, m_state == 3);
        check_eq("delay_left", delay_left, (m_state == 2) ? ED - (en_t - t_trig) : 0);
        check_eq("zone_latched", zone_latched, m_lat);
        check_eq("arm_fail", arm_fail, m_af & e);
        check_eq("code_err", code_err, m_ce & e);
        if (r) check_eq("next_state", next_state, e ? nx : m_state);
        @(posedge clk);
        model_update(nx);
    endtask

    task automatic idle(input int n, input logic [3:0] zi);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, zi, 4'b0000, 4'b0000);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; arm_req = 1'b0; disarm_req = 1'b0;
        code_in = 4'h0; zone_in = 4'b0000; zone_bypass = 4'b0000; zone_instant = 4'b0000;

        // Reset, arm, entry delay of exactly ED cycles, then the alarm.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, CODE, 4'b0000, 4'b0000, 4'b0000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'b0000, 4'b0000, 4'b0000);
        #1; check_eq("reset_state", state, 2'b00); check_eq("reset_alarm", alarm, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, CODE, 4'b0000, 4'b0000, 4'b0000);
        #1; check_eq("arm_ok", state, 2'b01);
        idle(1, 4'b0001);
        #1; check_eq("trig_state", state, 2'b10); check_eq("trig_delay", delay_left, 5'd16);
        idle(15, 4'b0000);
        #1; check_eq("delay_last", delay_left, 5'd1); check_eq("still_trig", state, 2'b10);
        idle(1, 4'b0000);
        #1; check_eq("delay_alarm", state, 2'b11); check_eq("delay_alarm_out", alarm, 1'b1);

        // Alarm hold expires with zones clear after AH cycles.
        idle(63, 4'b0000);
        #1; check_eq("hold_63", state, 2'b11);
        idle(1, 4'b0000);
        #1; check_eq("hold_rearm", state, 2'b01);

        // Fresh arm, then an instant zone goes straight to alarm.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, CODE, 4'b0000, 4'b0000, 4'b0000);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, CODE, 4'b0000, 4'b0000, 4'b0000);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0100, 4'b0000, 4'b0100);
        #1; check_eq("instant_state", state, 2'b11); check_eq("instant_latch", zone_latched, 4'b0100);

        // Arm refused with an open zone; accepted once that zone is bypassed.
        cyc(1'b1, 1'b1, 1'b0, 1'b1, CODE, 4'b0000, 4'b0000, 4'b0000);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, CODE, 4'b0010, 4'b0000, 4'b0000);
        #1; check_eq("arm_fail_pulse", arm_fail, 1'b1); check_eq("arm_fail_state", state, 2'b00);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, CODE, 4'b0010, 4'b0010, 4'b0000);
        #1; check_eq("bypass_arm", state, 2'b01);

        // Disarm on the last entry-delay cycle beats the expiry.
        idle(1, 4'b0001);
        idle(15, 4'b0000);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, CODE, 4'b0000, 4'b0000, 4'b0000);
        #1; check_eq("late_disarm", state, 2'b00); check_eq("late_disarm_alarm", alarm, 1'b0);

        // Three bad codes while armed raise the tamper alarm.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, CODE, 4'b0000, 4'b0000, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'h3, 4'b0000, 4'b0000, 4'b0000);
            #1; check_eq("bad_code_pulse", code_err, 1'b1);
        end
        check_eq("tamper_state", state, 2'b11);

        // Zones still open at hold expiry keep the alarm on; reset clears it mid-alarm.
        idle(AH, 4'b0001);
        #1; check_eq("hold_reload", state, 2'b11);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'b0001, 4'b0000, 4'b0000);
        #1; check_eq("mid_alarm_rst", state, 2'b00); check_eq("mid_alarm_rst_alarm", alarm, 1'b0);
        check_eq("mid_alarm_rst_latch", zone_latched, 4'b0000);

        // Randomized traffic alternating busy and quiet phases.
        for (int i = 0; i < 4000; i++) begin
            bit         busy, r, e, ar, dr;
            logic [3:0] code, zi, zb, zs;
            int         den;
            busy = ((i / 250) % 2) == 0;
            den  = busy ? 10 : 40;
            r    = ($urandom_range(0, 299) != 0);
            e    = ($urandom_range(0, 9) != 0);
            ar   = busy ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 60) == 0);
            dr   = busy ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 150) == 0);
            code = ($urandom_range(0, 3) != 0) ? CODE : 4'($urandom_range(0, 15));
            for (int b = 0; b < 4; b++) zi[b] = ($urandom_range(0, den - 1) == 0);
            zb   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            zs   = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            cyc(r, e, ar, dr, code, zi, zb, zs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_zone_ctrl.md
ALARM_ZONE_CTRL -- requirements
Module: alarm_zone_ctrl

Interface
REQ-001 Parameter NUM_ZONES, default 4, number of sensor zones (1..16).
REQ-002 Parameter ENTRY_DELAY, default 16, entry-delay length in cycles (>=1).
REQ-003 Parameter ALARM_HOLD, default 64, minimum alarm-on time in cycles (>=1).
REQ-004 Parameter CODE_W, default 4, width of the user code.
REQ-005 Parameter ARM_CODE, default 4'hA, valid arm/disarm code.
REQ-006 Parameter MAX_BAD, default 3, consecutive bad codes that cause tamper alarm (>=1).
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  reset, synchronous, active-low.
REQ-009 ena  in  1  enable; when 0, all registers hold.
REQ-010 arm_req  in  1  one-cycle arm request, qualified by code_in.
REQ-011 disarm_req  in  1  one-cycle disarm request, qualified by code_in.
REQ-012 code_in  in  CODE_W  user code sampled with arm_req/disarm_req.
REQ-013 zone_in  in  NUM_ZONES  sensor inputs, 1 = zone violated.
REQ-014 zone_bypass  in  NUM_ZONES  1 = zone ignored in every state.
REQ-015 zone_instant  in  NUM_ZONES  1 = zone skips entry delay.
REQ-016 alarm  out  1  registered; 1 only in ALARM_ON.
REQ-017 state  out  2  registered state: OFF=00, ARMED=01, TRIGGERED=10, ALARM_ON=11.
REQ-018 next_state  out  2  combinational next state.
REQ-019 zone_latched  out  NUM_ZONES  sticky record of zones that caused trigger/alarm.
REQ-020 delay_left  out  clog2(ENTRY_DELAY+1)  remaining entry-delay cycles; 0 outside TRIGGERED.
REQ-021 arm_fail  out  1  one-cycle pulse: arm refused.
REQ-022 code_err  out  1  one-cycle pulse: request with wrong code.

Function
REQ-023 Active zones = zone_in & ~zone_bypass; "valid req" = req with code_in==ARM_CODE.
REQ-024 ena=0: state, counters, zone_latched hold; arm_fail/code_err read 0; next_state=state.
REQ-025 OFF: valid arm_req with no active zone -> ARMED; clear zone_latched and bad-code count.
REQ-026 OFF: valid arm_req with any active zone -> stay OFF, arm_fail=1 next cycle.
REQ-027 ARMED: active instant zone -> ALARM_ON; else any active zone -> TRIGGERED, delay counter loaded ENTRY_DELAY.
REQ-028 TRIGGERED: delay_left decrements 1/cycle; on the cycle delay_left==1 -> ALARM_ON (exactly ENTRY_DELAY cycles in TRIGGERED).
REQ-029 TRIGGERED: active instant zone -> ALARM_ON immediately, regardless of counter.
REQ-030 ALARM_ON: hold counter loaded ALARM_HOLD on entry; after ALARM_HOLD cycles, no active zone -> ARMED, else stay and reload.
REQ-031 Valid disarm_req in ARMED/TRIGGERED/ALARM_ON -> OFF next cycle; disarm wins over any simultaneous zone event or counter expiry.
REQ-032 Simultaneous arm_req and disarm_req: disarm_req evaluated, arm_req ignored.
REQ-033 Wrong code on either req: code_err=1 next cycle, bad count +1 (saturating); valid req clears count.
REQ-034 Bad count reaching MAX_BAD in ARMED or TRIGGERED -> ALARM_ON; in OFF count only.
REQ-035 zone_latched |= active zones each cycle state is TRIGGERED or ALARM_ON, and on the ARMED exit edge; cleared only by successful arm or reset.
REQ-036 Req in OFF of disarm, or arm in non-OFF state, with valid code: no effect.

Reset
REQ-037 rst_n=0 at a clk edge: state=OFF, alarm=0, zone_latched=0, delay_left=0, hold counter=0, bad count=0, arm_fail=0, code_err=0; overrides ena and any request, including mid-delay or mid-alarm.

Verification (defaults)
REQ-038 Reset, arm_req code 4'hA, zones 0 -> state 01 next cycle; zone_in=4'b0001 -> state 10, delay_left 16, ALARM_ON after 16 cycles, alarm=1.
REQ-039 ARMED, zone_instant=4'b0100, zone_in=4'b0100 -> state 11 next cycle, zone_latched=4'b0100.
REQ-040 OFF, zone_in=4'b0010, arm_req code 4'hA -> arm_fail pulse, state 00; same with zone_bypass=4'b0010 -> state 01.
REQ-041 TRIGGERED with delay_left=1, disarm_req code 4'hA same cycle -> state 00, alarm stays 0.
REQ-042 ARMED, three disarm_req code 4'h3 -> three code_err pulses, state 11 after third.
REQ-043 ALARM_ON, zones clear -> state 01 after 64 cycles; zones active at expiry -> stays 11; rst_n=0 mid-alarm -> all outputs reset next edge.
